// File: rtl/sram_if_pkg.sv
// Shared definitions for sram-like request channels.
//   SIZE_*     : encodings of the 2-bit size field
//   sram_req_t : one request beat (write flag, size, address, write data)
package sram_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of small IDs (also intended for the future write buffer).
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   push, din     : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   head          : oldest entry
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are log2(DEPTH) bits wide and wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter_nx1.sv
// N-to-1 round-robin arbiter for sram-like request channels.
// A grant is held until its address handshake completes; accepted requests
// are tracked in an in-order ID FIFO that steers each data_ok back to its
// issuing port.
// Ports:
//   clk, resetn                         : clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_addr/m_wdata    : upstream requests, port i in slice i
//   m_rdata                             : read data broadcast (valid with m_data_ok)
//   m_addr_ok/m_data_ok                 : per-port address accept / response
//   s_req/s_wr/s_size/s_addr/s_wdata    : downstream request
//   s_rdata/s_addr_ok/s_data_ok         : downstream response
//   proto_err                           : sticky, s_data_ok seen with nothing outstanding
// Optional (SRAM_ARB_PERF_CNT_EN): grant_cnt (32 bits per port), stall_cnt.
module sram_like_arbiter_nx1
  import sram_if_pkg::*;
#(
  parameter int unsigned N_PORTS     = 3,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_PORTS-1:0]     m_req,
  input  logic [N_PORTS-1:0]     m_wr,
  input  logic [2*N_PORTS-1:0]   m_size,
  input  logic [32*N_PORTS-1:0]  m_addr,
  input  logic [32*N_PORTS-1:0]  m_wdata,
  output logic [31:0]            m_rdata,
  output logic [N_PORTS-1:0]     m_addr_ok,
  output logic [N_PORTS-1:0]     m_data_ok,
  output logic                   s_req,
  output logic                   s_wr,
  output logic [1:0]             s_size,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  input  logic [31:0]            s_rdata,
  input  logic                   s_addr_ok,
  input  logic                   s_data_ok,
  output logic                   proto_err
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [32*N_PORTS-1:0]  grant_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned ID_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  lock_id;
  logic             lock_vld;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  head;
  logic             any_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             handshake;
  logic             pop;
  sram_req_t        sel_req;

  // First requester at or above ptr; otherwise the lowest requester (which wraps).
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && req[i] && (ID_W'(i) >= ptr)) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && req[i]) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign any_req   = |m_req;
  assign cand      = rr_pick(m_req, rr_ptr);
  assign grant     = lock_vld ? lock_id : cand;
  // No bypass when full: a same-cycle pop does not free the slot until next cycle.
  assign s_req     = (lock_vld | any_req) & ~fifo_full;
  assign handshake = s_req & s_addr_ok;
  assign pop       = s_data_ok & ~fifo_empty;

  always_comb begin
    sel_req = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant == ID_W'(i)) begin
        sel_req.wr    = m_wr[i];
        sel_req.size  = m_size[2*i +: 2];
        sel_req.addr  = m_addr[32*i +: 32];
        sel_req.wdata = m_wdata[32*i +: 32];
      end
    end
  end

  assign s_wr    = s_req & sel_req.wr;
  assign s_size  = s_req ? sel_req.size  : '0;
  assign s_addr  = s_req ? sel_req.addr  : '0;
  assign s_wdata = s_req ? sel_req.wdata : '0;
  assign m_rdata = pop   ? s_rdata       : '0;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      m_addr_ok[i] = handshake && (grant == ID_W'(i));
      m_data_ok[i] = pop && (head == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (handshake) begin
        lock_vld <= 1'b0;
        rr_ptr   <= (grant == ID_W'(N_PORTS-1)) ? '0 : grant + 1'b1;
      end else if (s_req) begin
        lock_vld <= 1'b1;
        lock_id  <= grant;
      end
      if (s_data_ok && fifo_empty) proto_err <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (handshake),
    .pop    (pop),
    .din    (grant),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef SRAM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (handshake && (grant == ID_W'(i)))
          grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 32'd1;
      end
      if ((lock_vld | any_req) & fifo_full) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter_nx1.sv
// Directed self-checking bench for sram_like_arbiter_nx1 (N_PORTS=3, OUTSTANDING=4).
module tb_sram_like_arbiter_nx1;
  import sram_if_pkg::*;

  localparam int unsigned NP = 3;

  logic            clk;
  logic            resetn;
  logic [NP-1:0]   m_req;
  logic [NP-1:0]   m_wr;
  logic [2*NP-1:0] m_size;
  logic [32*NP-1:0] m_addr;
  logic [32*NP-1:0] m_wdata;
  logic [31:0]     m_rdata;
  logic [NP-1:0]   m_addr_ok;
  logic [NP-1:0]   m_data_ok;
  logic            s_req;
  logic            s_wr;
  logic [1:0]      s_size;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic            s_addr_ok;
  logic            s_data_ok;
  logic            proto_err;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [32*NP-1:0] grant_cnt;
  logic [31:0]      stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sram_like_arbiter_nx1 #(
    .N_PORTS     (NP),
    .OUTSTANDING (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .s_req     (s_req),
    .s_wr      (s_wr),
    .s_size    (s_size),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_addr_ok (s_addr_ok),
    .s_data_ok (s_data_ok),
    .proto_err (proto_err)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned p, input logic req, input logic wr,
                       input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    m_req[p]            = req;
    m_wr[p]             = wr;
    m_size[2*p +: 2]    = size;
    m_addr[32*p +: 32]  = addr;
    m_wdata[32*p +: 32] = wdata;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    logic [2:0] exp_aok [4];
    logic [2:0] exp_dok [4];
    resetn = 1'b0;
    clear_inputs();
    #1;
    // Reset state: every output idle.
    check("rst_s_req",     32'(s_req),     32'd0);
    check("rst_s_addr",    s_addr,         32'd0);
    check("rst_m_addr_ok", 32'(m_addr_ok), 32'd0);
    check("rst_m_data_ok", 32'(m_data_ok), 32'd0);
    check("rst_m_rdata",   m_rdata,        32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    #1;

    // T1: single read on port 0, addr_ok after 2 waits, data 3 cycles later.
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h1FC0_0000, 32'd0);
    #1;
    check("t1_s_req",     32'(s_req),     32'd1);
    check("t1_s_addr",    s_addr,         32'h1FC0_0000);
    check("t1_s_size",    32'(s_size),    32'(SIZE_WORD));
    check("t1_aok_wait0", 32'(m_addr_ok), 32'd0);
    tick();
    check("t1_aok_wait1", 32'(m_addr_ok), 32'd0);
    tick();
    s_addr_ok = 1'b1;
    #1;
    check("t1_aok",       32'(m_addr_ok), 32'b001);
    tick();
    m_req = '0; s_addr_ok = 1'b0;
    #1;
    check("t1_aok_once",  32'(m_addr_ok), 32'd0);
    check("t1_s_req_off", 32'(s_req),     32'd0);
    tick(); tick();
    s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_dok",   32'(m_data_ok), 32'b001);
    check("t1_rdata", m_rdata,        32'hDEAD_BEEF);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("t1_dok_once", 32'(m_data_ok), 32'd0);
    // rr_ptr now 1: with ports 0 and 1 both requesting, port 1 wins.
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h0000_0100, 32'd0);
    drive(1, 1'b1, 1'b0, SIZE_WORD, 32'h0000_0200, 32'd0);
    s_addr_ok = 1'b1;
    #1;
    check("t1_rr_aok",  32'(m_addr_ok), 32'b010);
    check("t1_rr_addr", s_addr,         32'h0000_0200);
    tick();
    m_req[1] = 1'b0;
    #1;
    check("t1_rr_aok2",  32'(m_addr_ok), 32'b001);
    check("t1_rr_addr2", s_addr,         32'h0000_0100);
    tick();
    m_req = '0; s_addr_ok = 1'b0;
    s_data_ok = 1'b1; s_rdata = 32'h55;
    #1;
    check("t1_rr_dok1", 32'(m_data_ok), 32'b010);
    tick();
    s_rdata = 32'h66;
    #1;
    check("t1_rr_dok2",   32'(m_data_ok), 32'b001);
    check("t1_rr_rdata2", m_rdata,        32'h66);
    tick();
    s_data_ok = 1'b0;

    // T2: all three ports requesting, downstream always ready.
    do_reset();
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h1000, 32'd0);
    drive(1, 1'b1, 1'b0, SIZE_WORD, 32'h2000, 32'd0);
    drive(2, 1'b1, 1'b0, SIZE_WORD, 32'h3000, 32'd0);
    s_addr_ok = 1'b1;
    exp_aok[0] = 3'b001; exp_aok[1] = 3'b010; exp_aok[2] = 3'b100; exp_aok[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_aok%0d", k), 32'(m_addr_ok), 32'(exp_aok[k]));
      tick();
    end
    #1;
    check("t2_full_s_req", 32'(s_req),               32'd0);
    check("t2_full_aok",   32'(m_addr_ok),           32'd0);
    check("t2_count4",     32'(dut.u_id_fifo.count), 32'd4);

    // T3: full, pop and pending request in the same cycle -> no bypass.
    s_data_ok = 1'b1; s_rdata = 32'hA5;
    #1;
    check("t3_s_req_blocked", 32'(s_req),     32'd0);
    check("t3_aok_blocked",   32'(m_addr_ok), 32'd0);
    check("t3_dok",           32'(m_data_ok), 32'b001);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("t3_count3", 32'(dut.u_id_fifo.count), 32'd3);
    check("t3_s_req",  32'(s_req),               32'd1);
    check("t3_aok",    32'(m_addr_ok),           32'b010);
    tick();
    #1;
    check("t3_count4b", 32'(dut.u_id_fifo.count), 32'd4);
    m_req = '0; s_addr_ok = 1'b0;
    s_data_ok = 1'b1;
    exp_dok[0] = 3'b010; exp_dok[1] = 3'b100; exp_dok[2] = 3'b001; exp_dok[3] = 3'b010;
    for (int k = 0; k < 4; k++) begin
      s_rdata = 32'(k + 1);
      #1;
      check($sformatf("t3_drain_dok%0d", k), 32'(m_data_ok), 32'(exp_dok[k]));
      check($sformatf("t3_drain_rd%0d", k),  m_rdata,        32'(k + 1));
      tick();
    end
    s_data_ok = 1'b0;
    #1;
    check("t3_count0", 32'(dut.u_id_fifo.count), 32'd0);

    // T4: offer on port 1 stalls; port 0 arrives but cannot steal the grant.
    do_reset();
    drive(1, 1'b1, 1'b1, SIZE_HALF, 32'h1111_0000, 32'hCAFE_F00D);
    #1;
    check("t4_s_addr",  s_addr,      32'h1111_0000);
    check("t4_s_wr",    32'(s_wr),   32'd1);
    check("t4_s_size",  32'(s_size), 32'(SIZE_HALF));
    check("t4_s_wdata", s_wdata,     32'hCAFE_F00D);
    tick();
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h0000_0AA0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t4_hold_addr%0d", k), s_addr,          32'h1111_0000);
      check($sformatf("t4_hold_aok%0d", k),  32'(m_addr_ok),  32'd0);
      tick();
    end
    s_addr_ok = 1'b1;
    #1;
    check("t4_aok1", 32'(m_addr_ok), 32'b010);
    tick();
    m_req[1] = 1'b0;
    #1;
    check("t4_aok0",  32'(m_addr_ok), 32'b001);
    check("t4_addr0", s_addr,         32'h0000_0AA0);
    check("t4_wr0",   32'(s_wr),      32'd0);
    tick();
    m_req = '0; s_addr_ok = 1'b0;
    #1;
    check("t4_idle_wdata", s_wdata, 32'd0);
    s_data_ok = 1'b1;
    #1;
    check("t4_dok_a", 32'(m_data_ok), 32'b010);
    tick();
    #1;
    check("t4_dok_b", 32'(m_data_ok), 32'b001);
    tick();
    s_data_ok = 1'b0;

    // T5: interleaved 2, 0, 2 -> responses routed 2, 0, 2.
    do_reset();
    s_addr_ok = 1'b1;
    drive(2, 1'b1, 1'b0, SIZE_WORD, 32'h2, 32'd0);
    #1;
    check("t5_aok_a", 32'(m_addr_ok), 32'b100);
    tick();
    m_req[2] = 1'b0;
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h0, 32'd0);
    #1;
    check("t5_aok_b", 32'(m_addr_ok), 32'b001);
    tick();
    m_req[0] = 1'b0; m_req[2] = 1'b1;
    #1;
    check("t5_aok_c", 32'(m_addr_ok), 32'b100);
    tick();
    m_req = '0; s_addr_ok = 1'b0;
    s_data_ok = 1'b1; s_rdata = 32'h11;
    #1;
    check("t5_dok_a", 32'(m_data_ok), 32'b100);
    check("t5_rd_a",  m_rdata,        32'h11);
    tick();
    s_rdata = 32'h22;
    #1;
    check("t5_dok_b", 32'(m_data_ok), 32'b001);
    check("t5_rd_b",  m_rdata,        32'h22);
    tick();
    s_rdata = 32'h33;
    #1;
    check("t5_dok_c", 32'(m_data_ok), 32'b100);
    check("t5_rd_c",  m_rdata,        32'h33);
    tick();
    s_data_ok = 1'b0;

    // T6: stray response, then reset with two outstanding.
    s_data_ok = 1'b1; s_rdata = 32'h77;
    #1;
    check("t6_stray_dok",    32'(m_data_ok), 32'd0);
    check("t6_stray_rdata",  m_rdata,        32'd0);
    check("t6_perr_before",  32'(proto_err), 32'd0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("t6_perr_set", 32'(proto_err), 32'd1);
    drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h40, 32'd0);
    s_addr_ok = 1'b1;
    tick(); tick();
    m_req = '0; s_addr_ok = 1'b0;
    #1;
    check("t6_count2",   32'(dut.u_id_fifo.count), 32'd2);
    check("t6_perr_sticky", 32'(proto_err),        32'd1);
    resetn = 1'b0;
    #1;
    check("t6_rst_count", 32'(dut.u_id_fifo.count), 32'd0);
    check("t6_rst_perr",  32'(proto_err),           32'd0);
    tick();
    resetn = 1'b1;
    s_data_ok = 1'b1; s_rdata = 32'h88;
    #1;
    check("t6_late_dok", 32'(m_data_ok), 32'd0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("t6_late_perr", 32'(proto_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
